seq_digit_multiplier: RTL and testbench

SEQ_DIGIT_MULTIPLIER -- requirements
Module: seq_digit_multiplier

---
 rtl/mult_pkg.sv | 24 ++
 rtl/mul2x2_digit.sv | 31 +++
 rtl/seq_digit_multiplier.sv | 157 +++++++++++++++
 tb/tb_seq_digit_multiplier.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential digit multiplier:
//   state_t    - controller states (IDLE, BUSY, DONE)
//   DIGIT_BITS - width of one operand digit (radix-4 digits)
//   exact_dp   - exact 2x2 digit product, also used to initialise the
//                optional correction table (DIGIT_CORR_EN)
// ---------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIGIT_BITS = 2;

  // Largest product is 3*3 = 9, so 4 bits always suffice.
  function automatic logic [3:0] exact_dp(input logic [1:0] a, input logic [1:0] b);
    return {2'b00, a} * {2'b00, b};
  endfunction

endpackage

// File: rtl/mul2x2_digit.sv
// ---------------------------------------------------------------------------
// mul2x2_digit
// Combinational product of two 2-bit digits.
// Optional macro: DIGIT_CORR_EN - when defined, the product is looked up in a
// caller-supplied 16 x 4-bit table indexed by {i_a, i_b}; otherwise the exact
// product is returned.
// Ports:
//   i_a, i_b  - input digits
//   i_table   - flattened table, entry k at bits [4k+3:4k] (DIGIT_CORR_EN only)
//   o_dp      - 4-bit digit product
// ---------------------------------------------------------------------------
module mul2x2_digit
  import mult_pkg::*;
(
  input  logic [1:0]  i_a,
  input  logic [1:0]  i_b,
`ifdef DIGIT_CORR_EN
  input  logic [63:0] i_table,
`endif
  output logic [3:0]  o_dp
);

`ifdef DIGIT_CORR_EN
  logic [3:0] w_idx;
  assign w_idx = {i_a, i_b};
  assign o_dp  = i_table[w_idx*4 +: 4];
`else
  assign o_dp  = exact_dp(i_a, i_b);
`endif

endmodule

// File: rtl/seq_digit_multiplier.sv
// ---------------------------------------------------------------------------
// seq_digit_multiplier
// Unsigned WIDTH x WIDTH multiplier that forms one radix-4 digit product per
// cycle and accumulates it into a 2*WIDTH-bit result (D*D cycles per product,
// D = WIDTH/2). Valid/ready handshake on both sides.
// Optional macro: DIGIT_CORR_EN - adds a writable 16 x 4-bit digit-product
// table (reset to exact products) plus the corr_* write port.
// Ports:
//   clk, rst            - clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   - operand handshake; in_ready high only when idle
//   A, B                - unsigned operands
//   out_valid/out_ready - result handshake; P held stable until accepted
//   P                   - registered product
//   corr_we/addr/data   - table write port (DIGIT_CORR_EN only)
// ---------------------------------------------------------------------------
module seq_digit_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   P
`ifdef DIGIT_CORR_EN
  ,
  input  logic                 corr_we,
  input  logic [3:0]           corr_addr,
  input  logic [3:0]           corr_data
`endif
);

  localparam int D     = WIDTH / 2;
  localparam int CW    = (D > 1) ? $clog2(D) : 1;
  localparam int ACC_W = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [ACC_W-1:0]   r_acc;
  logic [CW-1:0]      r_i;
  logic [CW-1:0]      r_j;
  logic [ACC_W-1:0]   r_p;
  logic               r_out_valid;
  logic               r_in_ready;

  logic [1:0]         w_a_d;
  logic [1:0]         w_b_d;
  logic [3:0]         w_dp;
  logic [ACC_W-1:0]   w_term;
  logic [ACC_W-1:0]   w_acc_next;

  assign w_a_d = r_a[DIGIT_BITS*r_i +: DIGIT_BITS];
  assign w_b_d = r_b[DIGIT_BITS*r_j +: DIGIT_BITS];

`ifdef DIGIT_CORR_EN
  // Table lives here so it shares the async reset; reads are combinational,
  // so a write takes effect for lookups on the edge after it lands.
  logic [3:0]  r_table [16];
  logic [63:0] w_table;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        r_table[k] <= exact_dp(2'(k >> 2), 2'(k));
      end
    end else if (corr_we) begin
      r_table[corr_addr] <= corr_data;
    end
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_flat
    assign w_table[gi*4 +: 4] = r_table[gi];
  end

  mul2x2_digit u_dp (
    .i_a     (w_a_d),
    .i_b     (w_b_d),
    .i_table (w_table),
    .o_dp    (w_dp)
  );
`else
  mul2x2_digit u_dp (
    .i_a  (w_a_d),
    .i_b  (w_b_d),
    .o_dp (w_dp)
  );
`endif

  // Digit (i,j) has weight 4^(i+j); sum wraps at 2*WIDTH bits.
  assign w_term     = ACC_W'(w_dp) << (DIGIT_BITS * (int'(r_i) + int'(r_j)));
  assign w_acc_next = r_acc + w_term;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_p         <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= A;
            r_b        <= B;
            r_acc      <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          r_acc <= w_acc_next;
          if (r_j == LAST) begin
            r_j <= '0;
            if (r_i == LAST) begin
              r_p         <= w_acc_next;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_i <= r_i + CW'(1);
            end
          end else begin
            r_j <= r_j + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign P         = r_p;

endmodule

// File: tb/tb_seq_digit_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_digit_multiplier
// Directed and randomised checks of seq_digit_multiplier (WIDTH = 8).
// Builds with or without DIGIT_CORR_EN; the table test runs only when defined.
// ---------------------------------------------------------------------------
module tb_seq_digit_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] P;
`ifdef DIGIT_CORR_EN
  logic        corr_we;
  logic [3:0]  corr_addr;
  logic [3:0]  corr_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_digit_multiplier #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (P)
`ifdef DIGIT_CORR_EN
    ,
    .corr_we   (corr_we),
    .corr_addr (corr_addr),
    .corr_data (corr_data)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one operation from a negedge; returns observed P. hold = cycles with
  // out_ready low once out_valid is seen; scramble drives junk on the input
  // side while busy.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold,
                        input bit scramble, output logic [15:0] p_obs);
    int t;
    int lat;
    p_obs = '0;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    A         = a;
    B         = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_in_ready", 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (scramble) begin
        A        = 8'($urandom);
        B        = 8'($urandom);
        in_valid = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      check("done_timeout", 64'(out_valid), 64'd1);
      return;
    end
    check("latency", 64'(lat), 64'd16);
    p_obs = P;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_p", 64'(P), 64'(p_obs));
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", 64'(out_valid), 64'd0);
    check("post_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [15:0] p;
    logic [7:0]  ra;
    logic [7:0]  rb;
    bit          seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
`ifdef DIGIT_CORR_EN
    corr_we   = 1'b0;
    corr_addr = '0;
    corr_data = '0;
`endif
    @(negedge clk);
    @(negedge clk);
    check("rst_p", 64'(P), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors
    run_op(8'hFF, 8'hFF, 0, 1'b0, p);
    $display("op A=ff B=ff P=%h", p);
    check("ff_x_ff", 64'(p), 64'hFE01);
    run_op(8'h00, 8'hB7, 0, 1'b0, p);
    $display("op A=00 B=b7 P=%h", p);
    check("00_x_b7", 64'(p), 64'h0000);
    run_op(8'h01, 8'hB7, 0, 1'b0, p);
    $display("op A=01 B=b7 P=%h", p);
    check("01_x_b7", 64'(p), 64'h00B7);
    run_op(8'h3C, 8'h5A, 5, 1'b0, p);
    $display("op A=3c B=5a hold=5 P=%h", p);
    check("3c_x_5a", 64'(p), 64'h1518);

    // Abort by reset in the middle of BUSY
    A        = 8'hAB;
    B        = 8'hCD;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_p", 64'(P), 64'd0);
    check("abort_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    $display("op abort by reset, out_valid seen=%0d", seen);
    run_op(8'h03, 8'h03, 0, 1'b0, p);
    $display("op A=03 B=03 P=%h", p);
    check("after_abort", 64'(p), 64'd9);

`ifdef DIGIT_CORR_EN
    corr_we   = 1'b1;
    corr_addr = 4'b1111;
    corr_data = 4'd0;
    @(negedge clk);
    corr_we = 1'b0;
    run_op(8'h03, 8'h03, 0, 1'b0, p);
    $display("op corr table[f]=0 A=03 B=03 P=%h", p);
    check("corr_3x3", 64'(p), 64'h0000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(8'h03, 8'h03, 0, 1'b0, p);
    $display("op corr after reset A=03 B=03 P=%h", p);
    check("corr_reset_3x3", 64'(p), 64'h0009);
`endif

    // Random operands with gaps and back-pressure
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(ra, rb, int'($urandom_range(0, 3)), 1'b1, p);
      $display("op rand A=%h B=%h P=%h", ra, rb, p);
      check("rand_p", 64'(p), 64'(ra) * 64'(rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
